// File: rtl/sync_ram_dp_arbiter_pkg.sv
// Shared encodings and slice helpers for the dual-port RAM arbiter.
// Pure definitions: no logic, no latency, no flow control.
package sync_ram_dp_arbiter_pkg;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // Low bit of element idx inside a packed vector of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sync_ram_dp.sv
// Two-port synchronous RAM, independent read/write on each port, no reset on contents.
// Latency: read data registered, valid one cycle after en; no backpressure.
module sync_ram_dp #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              en0_i,
    input  logic              we0_i,
    input  logic [AWIDTH-1:0] addr0_i,
    input  logic [DWIDTH-1:0] d0_i,
    output logic [DWIDTH-1:0] q0_o,
    input  logic              en1_i,
    input  logic              we1_i,
    input  logic [AWIDTH-1:0] addr1_i,
    input  logic [DWIDTH-1:0] d1_i,
    output logic [DWIDTH-1:0] q1_o
);

    logic [DWIDTH-1:0] mem_q [2**AWIDTH];

    always_ff @(posedge clk_i) begin
        if (en0_i) begin
            if (we0_i) mem_q[addr0_i] <= d0_i;
            else       q0_o           <= mem_q[addr0_i];
        end
        if (en1_i) begin
            if (we1_i) mem_q[addr1_i] <= d1_i;
            else       q1_o           <= mem_q[addr1_i];
        end
    end

endmodule

// File: rtl/sync_ram_dp_arbiter_rr_pick2.sv
// Round-robin picker granting up to two requesters with a cross-port hazard filter.
// Purely combinational; a hazarded candidate is skipped, not stalled.
module rr_pick2
    import sync_ram_dp_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int AWIDTH = 8,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]        valid_i,
    input  logic [IDW-1:0]         ptr_i,
    input  logic [NREQ*AWIDTH-1:0] addr_i,
    input  logic [NREQ-1:0]        we_i,
    output logic [NREQ-1:0]        gnt_a_o,
    output logic [NREQ-1:0]        gnt_b_o,
    output logic [IDW-1:0]         idx_a_o,
    output logic [IDW-1:0]         idx_b_o,
    output logic                   has_a_o,
    output logic                   has_b_o
);

    logic [AWIDTH-1:0] addr_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_addr
        assign addr_arr[g] = addr_i[slice_lo(g, AWIDTH) +: AWIDTH];
    end

    int             scan;
    logic [IDW-1:0] sel;
    logic           hazard;

    always_comb begin
        gnt_a_o = '0;
        gnt_b_o = '0;
        idx_a_o = '0;
        idx_b_o = '0;
        has_a_o = 1'b0;
        has_b_o = 1'b0;
        scan    = 0;
        sel     = '0;
        hazard  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            scan = int'(ptr_i) + k;
            if (scan >= NREQ) scan = scan - NREQ;
            sel = IDW'(scan);
            // Only meaningful once A exists; a write on either side makes a shared address unsafe.
            hazard = (addr_arr[sel] == addr_arr[idx_a_o]) &&
                     (we_i[idx_a_o] == OP_WR || we_i[sel] == OP_WR);
            if (valid_i[sel]) begin
                if (!has_a_o) begin
                    has_a_o      = 1'b1;
                    idx_a_o      = sel;
                    gnt_a_o[sel] = 1'b1;
                end else if (!has_b_o && !hazard) begin
                    has_b_o      = 1'b1;
                    idx_b_o      = sel;
                    gnt_b_o[sel] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sync_ram_dp_arbiter.sv
// Shares one dual-port RAM among NREQ requesters, two round-robin grants per cycle.
// Latency: read data one cycle after grant; no response backpressure, requesters may drop valid.
module sync_ram_dp_arbiter
    import sync_ram_dp_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*AWIDTH-1:0] req_addr,
    input  logic [NREQ*DWIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [NREQ*DWIDTH-1:0] rsp_rdata
);

    logic [DWIDTH-1:0] wdata_arr [NREQ];
    logic [AWIDTH-1:0] addr_arr  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign wdata_arr[g] = req_wdata[slice_lo(g, DWIDTH) +: DWIDTH];
        assign addr_arr[g]  = req_addr[slice_lo(g, AWIDTH) +: AWIDTH];
    end

    logic           armed_q;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           go;

    logic [NREQ-1:0] gnt_a, gnt_b;
    logic [IDW-1:0]  idx_a, idx_b;
    logic            has_a, has_b;

    rr_pick2 #(
        .NREQ   (NREQ),
        .AWIDTH (AWIDTH),
        .IDW    (IDW)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .addr_i  (req_addr),
        .we_i    (req_we),
        .gnt_a_o (gnt_a),
        .gnt_b_o (gnt_b),
        .idx_a_o (idx_a),
        .idx_b_o (idx_b),
        .has_a_o (has_a),
        .has_b_o (has_b)
    );

    // armed_q keeps grants off for the first cycle after reset releases.
    assign go = !rst && armed_q;

    logic              en0, we0, en1, we1;
    logic [AWIDTH-1:0] addr0, addr1;
    logic [DWIDTH-1:0] d0, d1, q0, q1;

    always_comb begin
        en0       = go && has_a;
        we0       = en0 && (req_we[idx_a] == OP_WR);
        addr0     = addr_arr[idx_a];
        d0        = wdata_arr[idx_a];
        en1       = go && has_b;
        we1       = en1 && (req_we[idx_b] == OP_WR);
        addr1     = addr_arr[idx_b];
        d1        = wdata_arr[idx_b];
        req_ready = go ? (gnt_a | gnt_b) : '0;
        rr_ptr_d  = rr_ptr_q;
        if (en1)      rr_ptr_d = IDW'(wrap_inc(int'(idx_b), NREQ));
        else if (en0) rr_ptr_d = IDW'(wrap_inc(int'(idx_a), NREQ));
    end

    sync_ram_dp #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk_i   (clk),
        .en0_i   (en0),
        .we0_i   (we0),
        .addr0_i (addr0),
        .d0_i    (d0),
        .q0_o    (q0),
        .en1_i   (en1),
        .we1_i   (we1),
        .addr1_i (addr1),
        .d1_i    (d1),
        .q1_o    (q1)
    );

    logic [1:0]     p_vld_q, p_rd_q;
    logic [IDW-1:0] p_idx_q [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q    <= 1'b0;
            rr_ptr_q   <= '0;
            p_vld_q    <= '0;
            p_rd_q     <= '0;
            p_idx_q[0] <= '0;
            p_idx_q[1] <= '0;
        end else begin
            armed_q    <= 1'b1;
            rr_ptr_q   <= rr_ptr_d;
            p_vld_q    <= {en1, en0};
            p_rd_q     <= {!we1, !we0};
            p_idx_q[0] <= idx_a;
            p_idx_q[1] <= idx_b;
        end
    end

    logic [NREQ-1:0]   rsp_hit;
    logic [DWIDTH-1:0] rsp_dat [NREQ];
    logic [DWIDTH-1:0] hold_q  [NREQ];

    // RAM q is live only in the response cycle; hold_q keeps the last value afterwards.
    always_comb begin
        rsp_hit = '0;
        for (int i = 0; i < NREQ; i++) rsp_dat[i] = hold_q[i];
        if (!rst) begin
            if (p_vld_q[0] && p_rd_q[0]) begin
                rsp_hit[p_idx_q[0]] = 1'b1;
                rsp_dat[p_idx_q[0]] = q0;
            end
            if (p_vld_q[1] && p_rd_q[1]) begin
                rsp_hit[p_idx_q[1]] = 1'b1;
                rsp_dat[p_idx_q[1]] = q1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) hold_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_hit[i]) hold_q[i] <= rsp_dat[i];
            end
        end
    end

    assign rsp_valid = rsp_hit;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign rsp_rdata[slice_lo(g, DWIDTH) +: DWIDTH] = rsp_dat[g];
    end

endmodule

// File: doc/sync_ram_dp_arbiter.md
Name: sync_ram_dp_arbiter

Overview:
- Shares one SYNC_RAM_DP instance between NREQ independent requesters using round-robin arbitration.
- Grants up to two requests per cycle: the first winner goes to RAM port 0, the second to RAM port 1.
- Returns read data to the issuing requester one cycle after grant.
- Blocks any grant pair that would create a cross-port address hazard.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWIDTH, 32, data width.
- AWIDTH, 8, address width; RAM depth is 2**AWIDTH.
- IDW, $clog2(NREQ), requester-index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  grant this cycle; the request is accepted when valid&ready.
- req_we  in  NREQ  1=write, 0=read.
- req_addr  in  NREQ*AWIDTH  packed addresses; requester i uses bits [i*AWIDTH +: AWIDTH].
- req_wdata  in  NREQ*DWIDTH  packed write data.
- rsp_valid  out  NREQ  read data valid, one-cycle pulse.
- rsp_rdata  out  NREQ*DWIDTH  packed read data; holds its value until the next response for that requester.

Behaviour:
- Reset: rr_ptr=0. req_ready=0 and rsp_valid=0 during rst and in the first cycle after it. rsp_rdata=0. The RAM is not cleared.
- Arbitration (combinational, each cycle when not in reset):
  - Scan requesters starting at rr_ptr, wrapping modulo NREQ.
  - First valid requester A gets port 0.
  - Continue scanning after A. The next valid requester B gets port 1 only if it is hazard-free.
  - Hazard: addr(B)==addr(A) and (we(A) or we(B)).
  - A hazard B stays ungranted this cycle; scanning continues to the following valid requester.
  - Two reads of the same address are not a hazard; both are granted.
- Grant limits: each requester receives at most one grant per cycle. req_ready is asserted only for granted requesters.
- Port drive:
  - en0=1 iff A exists; en1=1 iff B exists.
  - we/addr/d on each port are taken from its grantee.
  - Unused ports are driven with en=0, we=0.
- Pointer update: rr_ptr <= (index of last granted requester + 1) mod NREQ. Unchanged if no grant.
- Read latency:
  - A read granted in cycle t gives rsp_valid[i]=1 in cycle t+1, with rsp_rdata slice i = RAM q of the port used.
  - Keep a 1-stage pipeline per port: valid bit, requester index, read flag.
  - A write produces no response.
- Read-during-write on the same port cannot occur, because one grantee per port means one op per port.
- Cross-port same-address write conflicts are impossible by the hazard rule.
- Fairness: with all requesters continuously valid and no hazards, each requester is granted at least once every ceil(NREQ/2) cycles.
- Reset mid-operation:
  - A read granted in the cycle rst asserts is dropped; rsp_valid stays 0.
  - RAM writes already committed stay committed.
- req_valid may drop without a grant; there is no obligation to hold. Requesters must hold addr/we/wdata stable only in the cycle of the grant.
- No response backpressure: requesters must accept rsp_valid when it arrives.

Decomposition:
- Shared package holds:
  - an op-encoding constant, OP_RD=0 / OP_WR=1;
  - a function returning the packed slice index.
- Sub-module rr_pick2 (combinational):
  - inputs: valid vector, pointer, addresses, we;
  - outputs: gntA/gntB one-hot vectors, idxA, idxB, hasA, hasB.
- The top level holds rr_ptr, the response pipeline, the output registers and the SYNC_RAM_DP instance.

Test Plan:
- Reset, then write then read, single requester:
  - req 0 writes addr 0x10 data 0xDEADBEEF, then reads 0x10;
  - required: req_ready[0]=1 in both cycles; rsp_valid[0]=1 exactly one cycle after the read grant; rsp_rdata[0]=0xDEADBEEF.
- Dual grant:
  - reqs 0 and 1 read addrs 0x01 and 0x02, preloaded 0x11 and 0x22, with rr_ptr=0;
  - required: both ready in the same cycle; next cycle rsp_valid=0b0011 with data 0x11 and 0x22.
- Hazard:
  - req 0 writes 0x05, req 1 reads 0x05, req 2 reads 0x06, with rr_ptr=0;
  - required: ready=0b0101; req 1 is granted the next cycle and returns the new write data.
- Same-address reads:
  - reqs 2 and 3 both read 0x07;
  - required: ready=0b1100 in one cycle; both responses carry identical data.
- Fairness:
  - all 4 requesters continuously valid, distinct read addresses, for 20 cycles;
  - required: grants alternate 0b0011 / 0b1100; every requester is granted 10 times.
- Reset mid-read:
  - assert rst in the grant cycle of a read;
  - required: rsp_valid stays 0, rr_ptr returns to 0, and the first post-reset grant goes to the lowest valid index.
